// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// The memory samples imem_addr every cycle and answers with imem_ready/imem_rdata.
interface fetch_ifid_stage_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// RV32I instruction fetch plus IF/ID register with a one-entry hold buffer for stalls.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/wait/flush counters.
//
// state | meaning
// FETCH | imem request active, PC points at the word being fetched
// HOLD  | word for PC returned during a stall and sits in hold_buf; no request
module fetch_ifid_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_target,
  fetch_ifid_stage_if.master  imem,
  output logic [XLEN-1:0]     ifid_pc,
  output logic [XLEN-1:0]     ifid_pc_plus4,
  output logic [31:0]         ifid_inst,
  output logic                ifid_valid,
  output logic [4:0]          ifid_rs1,
  output logic [4:0]          ifid_rs2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_imem_wait_cycles,
  output logic [31:0]         perf_flushes
`endif
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next, pc_plus4;
  logic [31:0]     hold_buf, hold_buf_next;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_next;
  logic [31:0]     ifid_inst_q, ifid_inst_next;
  logic            ifid_valid_q, ifid_valid_next;

  assign pc_plus4 = pc + FOUR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      hold_buf     <= '0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      hold_buf     <= hold_buf_next;
      ifid_pc_q    <= ifid_pc_next;
      ifid_inst_q  <= ifid_inst_next;
      ifid_valid_q <= ifid_valid_next;
    end
  end

  // Redirect wins over everything; any word returned in that cycle is dropped.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    hold_buf_next   = hold_buf;
    ifid_pc_next    = ifid_pc_q;
    ifid_inst_next  = ifid_inst_q;
    ifid_valid_next = ifid_valid_q;

    if (branch_taken) begin
      pc_next         = {branch_target[XLEN-1:2], 2'b00};
      ifid_inst_next  = NOP_INST;
      ifid_valid_next = 1'b0;
      hold_buf_next   = '0;
      state_next      = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            if (stall) begin
              hold_buf_next = imem.imem_rdata;
              state_next    = HOLD;
            end else begin
              ifid_pc_next    = pc;
              ifid_inst_next  = imem.imem_rdata;
              ifid_valid_next = 1'b1;
              pc_next         = pc_plus4;
            end
          end else if (!stall) begin
            ifid_inst_next  = NOP_INST;
            ifid_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_pc_next    = pc;
            ifid_inst_next  = hold_buf;
            ifid_valid_next = 1'b1;
            pc_next         = pc_plus4;
            state_next      = FETCH;
          end
        end
      endcase
    end
  end

  assign imem.imem_req  = !rst && (state == FETCH);
  assign imem.imem_addr = pc;

  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_q + FOUR;
  assign ifid_inst     = ifid_inst_q;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_rs1      = ifid_inst_q[19:15];
  assign ifid_rs2      = ifid_inst_q[24:20];

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt, wait_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !branch_taken)
        stall_cnt <= sat_inc(stall_cnt);
      if ((state == FETCH) && imem.imem_req && !imem.imem_ready)
        wait_cnt <= sat_inc(wait_cnt);
      if (branch_taken)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign perf_stall_cycles     = stall_cnt;
  assign perf_imem_wait_cycles = wait_cnt;
  assign perf_flushes          = flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed vector table, PC wrap, random run against
// a queue-based reference model, and (with FETCH_PERF_CNT_EN) counter checks.
module tb_fetch_ifid_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_inst;
  logic        ifid_valid;
  logic [4:0]  ifid_rs1, ifid_rs2;
  logic [31:0] w_pc, w_pc_plus4, w_inst;
  logic        w_valid;
  logic [4:0]  w_rs1, w_rs2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] p_stall, p_wait, p_flush, pw_stall, pw_wait, pw_flush;
`endif

  int n_checks = 0;
  int n_err    = 0;

  fetch_ifid_stage_if #(.XLEN(32)) bus ();
  fetch_ifid_stage_if #(.XLEN(32)) bus_w ();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  assign bus.imem_rdata   = bus.imem_ready ? mem(bus.imem_addr) : 32'hDEAD_BEEF;
  assign bus_w.imem_rdata = mem(bus_w.imem_addr);
  assign bus_w.imem_ready = 1'b1;

  fetch_ifid_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus.master),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_inst(ifid_inst),
    .ifid_valid(ifid_valid), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cycles(p_stall), .perf_imem_wait_cycles(p_wait), .perf_flushes(p_flush)
`endif
  );

  fetch_ifid_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem(bus_w.master),
    .ifid_pc(w_pc), .ifid_pc_plus4(w_pc_plus4), .ifid_inst(w_inst),
    .ifid_valid(w_valid), .ifid_rs1(w_rs1), .ifid_rs2(w_rs2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cycles(pw_stall), .perf_imem_wait_cycles(pw_wait), .perf_flushes(pw_flush)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic        ready;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[16];

  // Reference model: the PC, what IF/ID shows, and a queue of words caught during a stall.
  logic [31:0] m_pc, m_ipc, m_iinst;
  logic        m_ivalid;
  logic [31:0] m_held[$];

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_iinst = NOP; m_ivalid = 1'b0;
    m_held.delete();
  endtask

  task automatic deliver(input logic [31:0] word);
    m_ipc = m_pc; m_iinst = word; m_ivalid = 1'b1; m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step();
    if (branch_taken) begin
      m_pc = {branch_target[31:2], 2'b00};
      m_iinst = NOP; m_ivalid = 1'b0;
      m_held.delete();
    end else if (m_held.size() != 0) begin
      if (!stall) deliver(m_held.pop_front());
    end else if (bus.imem_ready) begin
      if (stall) m_held.push_back(mem(m_pc));
      else deliver(mem(m_pc));
    end else if (!stall) begin
      m_iinst = NOP; m_ivalid = 1'b0;
    end
  endtask

  task automatic check_model();
    check("rnd_req", {31'b0, bus.imem_req}, {31'b0, (m_held.size() == 0) && !rst});
    check("rnd_addr", bus.imem_addr, m_pc);
    check("rnd_ifid_pc", ifid_pc, m_ipc);
    check("rnd_pc_plus4", ifid_pc_plus4, m_ipc + 32'd4);
    check("rnd_inst", ifid_inst, m_iinst);
    check("rnd_valid", {31'b0, ifid_valid}, {31'b0, m_ivalid});
    check("rnd_rs1", {27'b0, ifid_rs1}, {27'b0, m_iinst[19:15]});
    check("rnd_rs2", {27'b0, ifid_rs2}, {27'b0, m_iinst[24:20]});
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    bus.imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_inst;
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 1'b1, 32'h4};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 1'b1, 32'h8};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 1'b1, 32'hC};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 1'b1, 32'h10};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 1'b1, 32'h14};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 1'b0, 32'h14};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 1'b0, 32'h14};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 1'b1, 32'h18};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b0, 1'b1, 32'h18};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b0, 1'b1, 32'h18};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b0, 1'b1, 32'h18};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 1'b1, 32'h1C};
    vecs[12] = '{1'b1, 1'b1, 32'h103, 1'b1, 32'h18,  1'b0, 1'b1, 32'h100};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b1, 32'h104};
    vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h104};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 1'b1, 32'h108};

    do_reset();
    check("rst_req", {31'b0, bus.imem_req}, 32'h0);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_pc_plus4", ifid_pc_plus4, 32'h4);
    check("rst_inst", ifid_inst, NOP);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_addr", bus.imem_addr, 32'h0);
    check("wrap_addr0", bus_w.imem_addr, 32'hFFFF_FFFC);

    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br;
      branch_target = vecs[i].target; bus.imem_ready = vecs[i].ready;
      @(posedge clk);
      @(negedge clk);
      exp_inst = vecs[i].exp_valid ? mem(vecs[i].exp_pc) : NOP;
      check($sformatf("vec%0d_ifid_pc", i), ifid_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_inst", i), ifid_inst, exp_inst);
      check($sformatf("vec%0d_rs1", i), {27'b0, ifid_rs1}, {27'b0, exp_inst[19:15]});
      check($sformatf("vec%0d_rs2", i), {27'b0, ifid_rs2}, {27'b0, exp_inst[24:20]});
      check($sformatf("vec%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      if (i == 0) begin
        check("wrap_addr1", bus_w.imem_addr, 32'h0);
        check("wrap_ifid_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", w_pc_plus4, 32'h0);
        check("wrap_inst", w_inst, mem(32'hFFFF_FFFC));
      end
    end

    do_reset();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      rst           = (c == 300);
      stall         = ($urandom_range(0, 99) < 30);
      bus.imem_ready = ($urandom_range(0, 99) < 70);
      branch_taken  = ($urandom_range(0, 99) < 8);
      branch_target = $urandom;
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      check_model();
    end

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      stall          = (c < 5);
      bus.imem_ready = (c < 5) || (c == 8);
      branch_taken   = (c == 8);
      branch_target  = 32'h200;
      @(posedge clk);
      @(negedge clk);
    end
    branch_taken = 1'b0; stall = 1'b0; bus.imem_ready = 1'b1;
    check("perf_stall", p_stall, 32'd5);
    check("perf_wait", p_wait, 32'd2);
    check("perf_flush", p_flush, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("perf_stall_rst", p_stall, 32'd0);
    check("perf_wait_rst", p_wait, 32'd0);
    check("perf_flush_rst", p_flush, 32'd0);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. Owns the PC, issues instruction-memory requests, and presents the fetched instruction plus rs1/rs2 fields to decode. The hazard detection unit consumes these fields and returns `stall`. `stall` freezes this stage; a taken branch from EX redirects the PC and flushes IF/ID. A single-entry hold buffer keeps an instruction that returns during a stall.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  load-use stall from hazard detection unit; hold PC and IF/ID
- branch_taken  in  1  redirect request from EX; highest priority
- branch_target  in  XLEN  redirect PC
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (= PC)
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  data returned this cycle for current imem_addr
- ifid_pc  out  XLEN  PC of instruction in IF/ID
- ifid_pc_plus4  out  XLEN  ifid_pc + 4
- ifid_inst  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_rs1  out  5  ifid_inst[19:15], combinational from the register
- ifid_rs2  out  5  ifid_inst[24:20], combinational from the register

Behaviour:
- Reset (rst=1 at a clk edge):
  - PC=RESET_PC; state=FETCH; hold buffer empty.
  - ifid_inst=NOP_INST, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=4.
  - imem_req is 0 while rst=1.
  - Reset mid-operation discards any pending data.
- Memory contract:
  - Memory samples imem_addr every cycle; no outstanding transactions.
  - imem_addr may change while imem_req=1 and imem_ready=0.
  - imem_rdata is used only in the cycle imem_ready=1.
- States: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=PC.
  - imem_ready=1 and stall=0: IF/ID <= {PC, PC+4, imem_rdata, valid=1}; PC <= PC+4.
  - imem_ready=1 and stall=1: IF/ID unchanged; hold buffer <= imem_rdata; PC unchanged; go to HOLD.
  - imem_ready=0 and stall=0: IF/ID <= bubble (NOP_INST, valid=0, pc fields unchanged); PC unchanged.
  - imem_ready=0 and stall=1: IF/ID and PC unchanged.
- HOLD: imem_req=0.
  - stall=1: everything unchanged.
  - stall=0: IF/ID <= {PC, PC+4, buffer, valid=1}; PC <= PC+4; go to FETCH.
- Redirect (branch_taken=1) overrides stall, imem_ready and state:
  - PC <= {branch_target[XLEN-1:2], 2'b00}.
  - IF/ID <= bubble (NOP_INST, valid=0).
  - Hold buffer cleared; go to FETCH.
  - Any imem_rdata returned in that cycle is discarded.
- rst overrides branch_taken.
- Arithmetic: PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0); no exception.
- Latency: instruction available at IF/ID one cycle after its imem_ready (zero-wait memory gives 1 instr/cycle).
- No instruction is lost or duplicated across any stall/ready/redirect interleaving.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: three extra outputs, each 32 bits, saturating at 32'hFFFF_FFFF, cleared by rst:
  - perf_stall_cycles counts cycles with stall=1 and branch_taken=0.
  - perf_imem_wait_cycles counts FETCH cycles with imem_req=1 and imem_ready=0.
  - perf_flushes counts cycles with branch_taken=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, zero-wait memory returning addr-derived words (RESET_PC=0) -> after 3 edges ifid_pc=8, ifid_valid=1, ifid_inst=mem[8]; rs1/rs2 match inst fields.
- stall=1 for 2 cycles while IF/ID holds PC 0x10 -> IF/ID stays at 0x10 and imem_addr=0x14. Word returned at 0x14 enters HOLD. After stall drops, next edge ifid_pc=0x14 and imem_addr=0x18.
- imem_ready=0 for 3 cycles, stall=0 -> ifid_valid=0, ifid_inst=0x00000013 for 3 cycles; PC held; the next ready loads the correct word.
- branch_taken=1 with branch_target=0x103 while stall=1 and imem_ready=1 -> PC=0x100, ifid_valid=0, returned data dropped; next fetch at 0x100.
- RESET_PC=32'hFFFF_FFFC, zero-wait memory -> second fetch address is 0x0000_0000.
- With FETCH_PERF_CNT_EN: 5 stall cycles, 2 wait cycles, 1 branch -> counters read 5, 2, 1; rst clears all three to 0.
